// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the FIFO drain/unpack stages.
package fifo_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } unpk_state_t;

    // Beats per FIFO word.
    function automatic int unsigned unpk_beats(input int unsigned data_w,
                                               input int unsigned out_w);
        return data_w / out_w;
    endfunction

    // Width of the slice counter.
    function automatic int unsigned unpk_cnt_w(input int unsigned data_w,
                                               input int unsigned out_w);
        return $clog2(unpk_beats(data_w, out_w));
    endfunction

endpackage

// File: rtl/fifo_byte_unpacker.sv
// Drains a show-ahead FIFO and serialises each word into N narrow valid/ready beats,
// reloading on the last-beat handshake so consecutive words stream without bubbles.
module fifo_byte_unpacker
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned OUT_W     = 8,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              arst_n,
    output logic              rEn,
    input  logic [DATA_W-1:0] rData,
    input  logic              empty,
    output logic [OUT_W-1:0]  mData,
    output logic              mValid,
    input  logic              mReady,
    output logic              mLast
);

    localparam int unsigned N     = unpk_beats(DATA_W, OUT_W);
    localparam int unsigned CNT_W = unpk_cnt_w(DATA_W, OUT_W);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

    if (((DATA_W % OUT_W) != 0) || (N < 2)) begin : g_param_check
        $error("fifo_byte_unpacker: DATA_W must be a multiple of OUT_W with at least 2 beats");
    end

    unpk_state_t       state_q;
    logic [DATA_W-1:0] word_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  slice_idx;
    logic              hs;

    assign mValid = (state_q == SEND);
    assign mLast  = mValid && (cnt_q == LAST_IDX);
    assign hs     = mValid && mReady;

    // Pop when idle or when the final beat leaves; gated by reset so the FIFO never pops in reset.
    assign rEn = arst_n && !empty && ((state_q == IDLE) || (hs && mLast));

    assign slice_idx = LSB_FIRST ? cnt_q : (LAST_IDX - cnt_q);

    always_comb begin
        mData = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (slice_idx == CNT_W'(i)) begin
                mData = word_q[i*OUT_W +: OUT_W];
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rEn) begin
                        word_q  <= rData;
                        cnt_q   <= '0;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    // Stalled sink holds every register, keeping the beat stable.
                    if (hs) begin
                        if (!mLast) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end else if (rEn) begin
                            word_q <= rData;
                            cnt_q  <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_byte_unpacker.sv
// Bench for fifo_byte_unpacker: a queue-based FIFO feeds an LSB-first and an MSB-first
// instance in lockstep; a beat-queue model predicts every output each cycle.
module tb_fifo_byte_unpacker;

    logic        clk;
    logic        arst_n;
    logic        mReady;
    logic        empty;
    logic [31:0] rData;

    logic        rEn0, mValid0, mLast0;
    logic [7:0]  mData0;
    logic        rEn1, mValid1, mLast1;
    logic [7:0]  mData1;

    fifo_byte_unpacker #(.DATA_W(32), .OUT_W(8), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .arst_n(arst_n), .rEn(rEn0), .rData(rData), .empty(empty),
        .mData(mData0), .mValid(mValid0), .mReady(mReady), .mLast(mLast0)
    );

    fifo_byte_unpacker #(.DATA_W(32), .OUT_W(8), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .arst_n(arst_n), .rEn(rEn1), .rData(rData), .empty(empty),
        .mData(mData1), .mValid(mValid1), .mReady(mReady), .mLast(mLast1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] fifo_q[$];
    logic [7:0]  exp_lsb[$];
    logic [7:0]  exp_msb[$];
    int          rem   = 0;
    int          pops  = 0;
    int          beats = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_d0, prev_d1;

    logic        s_ren, s_valid, s_last;
    logic [7:0]  s_d0, s_d1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_fifo();
        empty = (fifo_q.size() == 0);
        rData = empty ? $urandom : fifo_q[0];
    endtask

    // Expected outputs derive from "beats left in the word being sent" and the queued bytes.
    task automatic check_cycle();
        logic exp_valid, exp_last, exp_ren, hs;
        exp_valid = (rem > 0);
        exp_last  = (rem == 1);
        hs        = exp_valid && mReady;
        exp_ren   = arst_n && !empty && ((rem == 0) || (exp_last && mReady));

        chk("mValid_lsb", 32'(mValid0), 32'(exp_valid));
        chk("mValid_msb", 32'(mValid1), 32'(exp_valid));
        chk("mLast_lsb", 32'(mLast0), 32'(exp_valid && exp_last));
        chk("mLast_msb", 32'(mLast1), 32'(exp_valid && exp_last));
        chk("rEn_lsb", 32'(rEn0), 32'(exp_ren));
        chk("rEn_msb", 32'(rEn1), 32'(exp_ren));
        if (exp_valid) begin
            chk("mData_lsb", 32'(mData0), 32'(exp_lsb[0]));
            chk("mData_msb", 32'(mData1), 32'(exp_msb[0]));
        end
        if (prev_stall) begin
            chk("stall_hold_lsb", 32'(mData0), 32'(prev_d0));
            chk("stall_hold_msb", 32'(mData1), 32'(prev_d1));
        end
        prev_stall = exp_valid && !mReady;
        prev_d0    = mData0;
        prev_d1    = mData1;

        s_ren = rEn0; s_valid = mValid0; s_last = mLast0; s_d0 = mData0; s_d1 = mData1;

        if (hs) begin
            void'(exp_lsb.pop_front());
            void'(exp_msb.pop_front());
            rem--;
            beats++;
        end
        if (exp_ren) begin
            for (int i = 0; i < 4; i++) begin
                exp_lsb.push_back(rData[8*i +: 8]);
                exp_msb.push_back(rData[8*(3-i) +: 8]);
            end
            rem = 4;
            pops++;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        if (s_ren && fifo_q.size() > 0) void'(fifo_q.pop_front());
        drive_fifo();
    endtask

    task automatic push(input logic [31:0] w);
        fifo_q.push_back(w);
        drive_fifo();
    endtask

    logic [7:0] got0[5];
    logic [7:0] got1[5];
    logic       gv[14];
    logic       gr[14];
    logic       gl[5];

    initial begin
        int p0, cyc, pushed, b0;
        arst_n = 1'b0;
        mReady = 1'b0;
        drive_fifo();

        // Reset values, with a word already waiting in the FIFO.
        push(32'h0BAD_F00D);
        step();
        chk("reset_mValid", 32'(s_valid), 32'h0);
        chk("reset_mLast", 32'(s_last), 32'h0);
        chk("reset_mData", 32'(s_d0), 32'h0);
        chk("reset_rEn", 32'(s_ren), 32'h0);
        void'(fifo_q.pop_front());
        drive_fifo();
        step();
        arst_n = 1'b1;

        // Single word, continuous ready.
        mReady = 1'b1;
        p0 = pops;
        push(32'h4433_2211);
        for (int c = 0; c < 6; c++) begin
            step();
            gv[c] = s_valid;
            gr[c] = s_ren;
            if (c < 5) begin got0[c] = s_d0; got1[c] = s_d1; gl[c] = s_last; end
        end
        chk("w1_ren_c0", 32'(gr[0]), 32'h1);
        chk("w1_valid_c0", 32'(gv[0]), 32'h0);
        chk("w1_beat0", 32'(got0[1]), 32'h11);
        chk("w1_beat1", 32'(got0[2]), 32'h22);
        chk("w1_beat2", 32'(got0[3]), 32'h33);
        chk("w1_beat3", 32'(got0[4]), 32'h44);
        chk("w1_msb_beat0", 32'(got1[1]), 32'h44);
        chk("w1_last_early", 32'(gl[3]), 32'h0);
        chk("w1_last_final", 32'(gl[4]), 32'h1);
        chk("w1_valid_after", 32'(gv[5]), 32'h0);
        chk("w1_pop_count", 32'(pops - p0), 32'h1);

        // Three preloaded words stream back-to-back.
        push(32'h0302_0100);
        push(32'h0706_0504);
        push(32'h0B0A_0908);
        for (int c = 0; c < 14; c++) begin
            step();
            gv[c] = s_valid;
            gr[c] = s_ren;
        end
        for (int c = 0; c < 14; c++) begin
            chk($sformatf("b2b_ren_c%0d", c), 32'(gr[c]), 32'((c == 0) || (c == 4) || (c == 8)));
            chk($sformatf("b2b_valid_c%0d", c), 32'(gv[c]), 32'((c >= 1) && (c <= 12)));
        end
        chk("b2b_fifo_empty", 32'(empty), 32'h1);

        // MSB-first ordering on the second instance.
        push(32'hA1B2_C3D4);
        for (int c = 0; c < 5; c++) begin
            step();
            got0[c] = s_d0;
            got1[c] = s_d1;
        end
        chk("msb_beat0", 32'(got1[1]), 32'hA1);
        chk("msb_beat1", 32'(got1[2]), 32'hB2);
        chk("msb_beat2", 32'(got1[3]), 32'hC3);
        chk("msb_beat3", 32'(got1[4]), 32'hD4);
        chk("lsb_of_same_beat0", 32'(got0[1]), 32'hD4);
        step();

        // Reset after two beats: remainder of the word is discarded.
        push(32'h5566_7788);
        push(32'h99AA_BBCC);
        for (int c = 0; c < 3; c++) step();
        #1;
        arst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(mValid0), 32'h0);
        chk("rst_mid_rEn", 32'(rEn0), 32'h0);
        rem = 0;
        exp_lsb.delete();
        exp_msb.delete();
        prev_stall = 1'b0;
        step();
        step();
        arst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            if (c < 5) got0[c] = s_d0;
        end
        chk("rst_restart_beat0", 32'(got0[1]), 32'hCC);
        chk("rst_restart_beat3", 32'(got0[4]), 32'h99);

        // Long sink stall with a full FIFO.
        mReady = 1'b0;
        push(32'hDEAD_BEEF);
        push(32'h1234_5678);
        push(32'h0F0E_0D0C);
        push(32'hCAFE_F00D);
        step();
        p0 = pops;
        for (int c = 0; c < 50; c++) step();
        chk("stall_no_pops", 32'(pops - p0), 32'h0);
        chk("stall_hold_first", 32'(s_d0), 32'hEF);
        chk("stall_fifo_kept", 32'(fifo_q.size()), 32'd3);
        mReady = 1'b1;
        cyc = 0;
        while ((fifo_q.size() > 0 || rem > 0) && cyc < 40) begin
            step();
            cyc++;
        end
        chk("stall_drain_done", 32'(cyc < 40), 32'h1);

        // Random traffic: random pushes and 50% sink ready.
        pushed = 0;
        cyc = 0;
        b0 = beats;
        while ((pushed < 1000 || fifo_q.size() > 0 || rem > 0) && cyc < 30000) begin
            if (pushed < 1000 && fifo_q.size() < 8 && $urandom_range(0, 2) == 0) begin
                push($urandom);
                pushed++;
            end
            mReady = 1'($urandom_range(0, 1));
            step();
            cyc++;
        end
        chk("random_done", 32'(cyc < 30000), 32'h1);
        chk("random_beats", 32'(beats - b0), 32'd4000);
        mReady = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_byte_unpacker.md
# fifo_byte_unpacker

Downstream drain stage for `sync_fifo`. Pops `DATA_W`-bit words from the FIFO read port and serialises each word into `DATA_W/OUT_W` narrow beats on a valid/ready stream, e.g. for a byte-wide UART or SPI transmitter. The block sustains one beat per clock with no bubbles between words and never reads an empty FIFO.

## Interface
Parameters:
- `DATA_W`, 32: FIFO word width; must be an integer multiple of `OUT_W`.
- `OUT_W`, 8: output beat width.
- `LSB_FIRST`, 1: 1 sends bits `[OUT_W-1:0]` first; 0 sends the most-significant slice first.

Derived: `N = DATA_W/OUT_W` (must be ≥2); `CNT_W = $clog2(N)`.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1: single clock, shared with `sync_fifo`.
- `arst_n`  in  1: asynchronous active-low reset.
- `rEn`  out  1: FIFO pop; combinational.
- `rData`  in  DATA_W: FIFO head word, valid whenever `empty`=0 (show-ahead).
- `empty`  in  1: FIFO empty flag.
- `mData`  out  OUT_W: current output beat.
- `mValid`  out  1: beat valid.
- `mReady`  in  1: sink accepts the beat.
- `mLast`  out  1: current beat is the final slice of its word.

## Operation
Registers:
- `word_q[DATA_W]`
- `cnt_q[CNT_W]`: index of the current slice.
- `state_q ∈ {IDLE, SEND}`

Slice selection: `mData` = slice `cnt_q` (LSB_FIRST=1) or slice `N-1-cnt_q` (LSB_FIRST=0) of `word_q`.

Outputs:
- `mValid` = (`state_q`==SEND).
- `mLast` = `mValid` & (`cnt_q`==N-1).

Beat handshake: `hs` = `mValid` & `mReady`.

Pop rule:
- `rEn` = `~empty` & ((`state_q`==IDLE) | (`hs` & `mLast`)).
- `rEn` is never 1 while `empty`=1 or while `arst_n`=0.

Transitions:
- IDLE, `rEn`=1: `word_q`←`rData`, `cnt_q`←0, go to SEND.
- IDLE, `rEn`=0: stay in IDLE.
- SEND, `hs` & ~`mLast`: `cnt_q`←`cnt_q`+1.
- SEND, `hs` & `mLast` & `rEn`: `word_q`←`rData`, `cnt_q`←0, stay in SEND (back-to-back words).
- SEND, `hs` & `mLast` & ~`rEn`: go to IDLE.
- SEND, ~`mReady`: hold all registers. `mData`/`mValid`/`mLast` stay stable (AXI-style rule: no withdrawal or change while stalled).

Other rules:
- `mValid` never depends combinationally on `mReady`.
- `rEn` does depend combinationally on `mReady`.
- The counter is exact `CNT_W` bits; N need not be a power of 2. Wrap back to 0 only happens via reload.

Reset mid-operation: `state_q`→IDLE, `cnt_q`→0, `word_q`→0. The word being serialised is discarded. FIFO contents are untouched, because `sync_fifo` shares `arst_n`.

## Timing
- Reset values: `mValid`=0, `mLast`=0, `mData`=0, `rEn`=0.
- Latency: FIFO goes non-empty before edge k → `rEn`=1 in cycle k → first beat `mValid`=1 from cycle k+1.
- Throughput: with `mReady`=1 continuously and the FIFO never empty, one beat per cycle, with no idle cycle at word boundaries.
- If the FIFO becomes empty at a word boundary, `mValid` drops for at least one cycle. Restart latency is 1 cycle after `empty` falls.
- Sink stall (`mReady`=0) for any number of cycles: no FIFO pops, no beat lost or duplicated.
- `empty` falling and a last-beat handshake in the same cycle: the reload happens in that cycle; no IDLE gap.

## Structure
- Shared package `fifo_pkg`:
  - `typedef enum logic {IDLE, SEND} unpk_state_t`
  - `localparam` helper for `N`/`CNT_W`
  - elaboration check: `DATA_W % OUT_W == 0`, `N≥2`
- Single module, no sub-module. Slice selection is an indexed part-select. Target size is about 120–180 lines.

## Test plan
- Reset, then push `32'h44332211` (LSB_FIRST=1) with `mReady`=1 → beats `11,22,33,44`, `mLast` only on `44`, exactly one `rEn` pulse, `mValid` rises 1 cycle after `empty` falls.
- Preload 3 words, `mReady`=1 → 12 consecutive beats with no gaps, `rEn` high on cycles 0, 4, 8; then `mValid`=0 and FIFO empty.
- LSB_FIRST=0 with word `32'hA1B2C3D4` → beats `A1,B2,C3,D4`.
- Random `mReady` (50%) with 1000 random words pushed at random times → output byte stream equals the scoreboard; `rEn` is never 1 while `empty`=1; `mData`/`mValid` are stable during every stall.
- Assert `arst_n`=0 mid-word (after 2 beats) → `mValid`=0 immediately. After release, the next word starts at slice 0 and the remaining bytes of the old word are never emitted.
- `mReady`=0 for 50 cycles while the FIFO is full → zero pops; `mData` holds its first beat throughout.
